// File: rtl/cpu_pkg.sv
// Shared fetch-path constants, state/redirect enums and a word-alignment helper.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {BOOT, RUN, TRAP} fetch_state_e;

  typedef enum logic [2:0] {SEQ, JMP, BR, EXC, IRQ, HOLD} redirect_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC priority selector: exception, branch, interrupt, jump, stall, sequential.
module fetch_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        illop_i,
  input  logic        irq_take_i,
  output redirect_e   src_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] jump_pc;

  // User-mode code may not set bit 31 through a jump; kernel code keeps the target as given.
  assign jump_pc = word_align(jump_target_i) & {pc_i[31], 31'h7FFF_FFFF};

  always_comb begin
    src_o     = SEQ;
    next_pc_o = pc_i + 32'd4;
    if (illop_i) begin
      src_o     = EXC;
      next_pc_o = ILLOP_VEC;
    end else if (branch_i) begin
      src_o     = BR;
      next_pc_o = word_align(branch_target_i);
    end else if (irq_take_i) begin
      src_o     = IRQ;
      next_pc_o = XADR_VEC;
    end else if (jump_i) begin
      src_o     = JMP;
      next_pc_o = jump_pc;
    end else if (stall_i) begin
      src_o     = HOLD;
      next_pc_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC register, IF/ID latch, EPC capture and BOOT/RUN/TRAP sequencing for the fetch stage.
// Optional macro DELAY_SLOT_EN: jumps keep the already-fetched delay-slot instruction.
module fetch_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        illop_i,
  input  logic        irq_i,
  output logic [31:0] ifid_inst_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] epc_o,
  output logic        flush_idex_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ifid_inst_q, ifid_inst_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  epc_q, epc_d;
  logic         irq_pend_q, irq_pend_d;
  logic         flush_idex;
  logic         irq_take;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  redirect_e    src;

  assign pc_plus4 = pc_q + 32'd4;
  // Interrupts are only accepted from user code, and never in the cycle right after a trap.
  assign irq_take = irq_pend_q & ~pc_q[31] & (state_q == RUN);

  fetch_next_pc u_next_pc (
    .pc_i           (pc_q),
    .stall_i        (stall_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .illop_i        (illop_i),
    .irq_take_i     (irq_take),
    .src_o          (src),
    .next_pc_o      (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    epc_d        = epc_q;
    flush_idex   = 1'b0;
    irq_pend_d   = (src == IRQ) ? 1'b0 : (irq_pend_q | irq_i);

    if (state_q == BOOT) begin
      pc_d    = pc_plus4;
      state_d = RUN;
    end else begin
      state_d = RUN;
      case (src)
        EXC: begin
          pc_d         = next_pc;
          epc_d        = ifid_pc4_q - 32'd4;
          ifid_inst_d  = NOP_WORD;
          ifid_valid_d = 1'b0;
          flush_idex   = 1'b1;
          state_d      = TRAP;
        end
        BR: begin
          pc_d         = next_pc;
          ifid_inst_d  = NOP_WORD;
          ifid_valid_d = 1'b0;
          flush_idex   = 1'b1;
        end
        IRQ: begin
          pc_d         = next_pc;
          epc_d        = pc_q;
          ifid_inst_d  = NOP_WORD;
          ifid_valid_d = 1'b0;
          state_d      = TRAP;
        end
        JMP: begin
          pc_d         = next_pc;
`ifdef DELAY_SLOT_EN
          ifid_inst_d  = inst_i;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
`else
          ifid_inst_d  = NOP_WORD;
          ifid_valid_d = 1'b0;
`endif
        end
        HOLD: begin
          flush_idex   = 1'b1;
        end
        default: begin
          pc_d         = next_pc;
          ifid_inst_d  = inst_i;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VEC;
      ifid_inst_q  <= NOP_WORD;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      epc_q        <= 32'd0;
      irq_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      epc_q        <= epc_d;
      irq_pend_q   <= irq_pend_d;
    end
  end

  assign pc_o         = pc_q;
  assign ifid_inst_o  = ifid_inst_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_valid_o = ifid_valid_q;
  assign epc_o        = epc_q;
  assign flush_idex_o = flush_idex & ~reset;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors queued, monitor compares at negedge.
module tb_fetch_sequencer;

  localparam logic [31:0] DC = 32'hFFFF_FFFF;
  localparam logic [31:0] K  = 32'h8000_0000;
`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        illop_i;
  logic        irq_i;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [31:0] epc_o;
  logic        flush_idex_o;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] epc;
    logic        valid;
    logic        flush;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   stepId     = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .pc_o           (pc_o),
    .inst_i         (inst_i),
    .stall_i        (stall_i),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .branch_i       (branch_i),
    .branch_target_i(branch_target_i),
    .illop_i        (illop_i),
    .irq_i          (irq_i),
    .ifid_inst_o    (ifid_inst_o),
    .ifid_pc4_o     (ifid_pc4_o),
    .ifid_valid_o   (ifid_valid_o),
    .epc_o          (epc_o),
    .flush_idex_o   (flush_idex_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  assign inst_i = rom(pc_o);

  task automatic checkOutput(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
    if (exp !== DC) begin
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("[TB] FAIL step%0d %s: got %h expected %h", id, what, act, exp);
      end
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the outputs must show in that cycle.
  task automatic applyStimulus(input logic rst, input logic st, input logic jmp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt, input logic ill, input logic irq,
                               input logic [31:0] ePc, input logic [31:0] eInst, input logic [31:0] ePc4,
                               input logic eValid, input logic [31:0] eEpc, input logic eFlush);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    stall_i         = st;
    jump_i          = jmp;
    jump_target_i   = jt;
    branch_i        = br;
    branch_target_i = bt;
    illop_i         = ill;
    irq_i           = irq;
    e.id    = stepId;
    e.pc    = ePc;
    e.inst  = eInst;
    e.pc4   = ePc4;
    e.epc   = eEpc;
    e.valid = eValid;
    e.flush = eFlush;
    expQ.push_back(e);
    stepId++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput(e.id, "pc_o", pc_o, e.pc);
      checkOutput(e.id, "ifid_inst_o", ifid_inst_o, e.inst);
      checkOutput(e.id, "ifid_pc4_o", ifid_pc4_o, e.pc4);
      checkOutput(e.id, "ifid_valid_o", {31'd0, ifid_valid_o}, {31'd0, e.valid});
      checkOutput(e.id, "epc_o", epc_o, e.epc);
      checkOutput(e.id, "flush_idex_o", {31'd0, flush_idex_o}, {31'd0, e.flush});
    end
  end

  initial begin
    reset = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_target_i = '0;
    branch_i = 1'b0; branch_target_i = '0; illop_i = 1'b0; irq_i = 1'b0;
    repeat (2) @(posedge clk);
    //            rst st jmp jt            br bt            ill irq  pc            inst                   pc4                 v   epc           fl
    applyStimulus(1, 0, 0, 0,            0, 0,            0, 0,  K,            0,                     0,                  0,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K,            0,                     0,                  0,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+4,          0,                     0,                  0,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+8,          rom(K+4),              K+8,                1,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+'hC,        rom(K+8),              K+'hC,              1,  0,            0);
    applyStimulus(0, 1, 0, 0,            0, 0,            0, 0,  K+'h10,       rom(K+'hC),            K+'h10,             1,  0,            1);
    applyStimulus(0, 1, 0, 0,            0, 0,            0, 0,  K+'h10,       rom(K+'hC),            K+'h10,             1,  0,            1);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+'h10,       rom(K+'hC),            K+'h10,             1,  0,            0);
    applyStimulus(0, 1, 0, 0,            1, K+'h38,       0, 0,  K+'h14,       rom(K+'h10),           K+'h14,             1,  0,            1);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+'h38,       0,                     DC,                 0,  0,            0);
    applyStimulus(0, 0, 1, 32'h40,       0, 0,            0, 1,  K+'h3C,       rom(K+'h38),           K+'h3C,             1,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  32'h40,       DS ? rom(K+'h3C) : 0,  DS ? K+'h40 : DC,   DS, 0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 1,  K+8,          0,                     DC,                 0,  32'h40,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+'hC,        rom(K+8),              K+'hC,              1,  32'h40,       0);
    applyStimulus(0, 0, 1, 32'h80,       0, 0,            0, 0,  K+'h10,       rom(K+'hC),            K+'h10,             1,  32'h40,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  32'h80,       DS ? rom(K+'h10) : 0,  DS ? K+'h14 : DC,   DS, 32'h40,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+8,          0,                     DC,                 0,  32'h80,       0);
    applyStimulus(0, 0, 1, 32'h44,       0, 0,            0, 0,  K+'hC,        rom(K+8),              K+'hC,              1,  32'h80,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  32'h44,       DS ? rom(K+'hC) : 0,   DS ? K+'h10 : DC,   DS, 32'h80,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            1, 0,  32'h48,       rom(32'h44),           32'h48,             1,  32'h80,       1);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+4,          0,                     DC,                 0,  32'h44,       0);
    applyStimulus(0, 0, 1, 32'h100,      0, 0,            0, 0,  K+8,          rom(K+4),              K+8,                1,  32'h44,       0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  32'h100,      DS ? rom(K+8) : 0,     DS ? K+'hC : DC,    DS, 32'h44,       0);
    applyStimulus(0, 0, 1, 32'h8000_0203,0, 0,            0, 0,  32'h104,      rom(32'h100),          32'h104,            1,  32'h44,       0);
    applyStimulus(0, 0, 0, 0,            1, 32'hFFFF_FFFE,0, 0,  32'h200,      DS ? rom(32'h104) : 0, DS ? 32'h108 : DC,  DS, 32'h44,       1);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  32'hFFFF_FFFC,0,                     DC,                 0,  32'h44,       0);
    applyStimulus(0, 0, 1, 32'h600,      1, 32'h500,      1, 0,  32'h0,        rom(32'hFFFF_FFFC),    32'h0,              1,  32'h44,       1);
    applyStimulus(0, 0, 0, 0,            1, 32'h300,      0, 0,  K+4,          0,                     DC,                 0,  32'hFFFF_FFFC,1);
    applyStimulus(1, 0, 0, 0,            1, 32'h400,      0, 0,  32'h300,      0,                     DC,                 0,  32'hFFFF_FFFC,0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K,            0,                     0,                  0,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+4,          0,                     0,                  0,  0,            0);
    applyStimulus(0, 0, 0, 0,            0, 0,            0, 0,  K+8,          rom(K+4),              K+8,                1,  0,            0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
